// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared state type and default field widths for the CAN bit timing unit
package can_pkg;

    typedef enum logic [1:0] {BT_SYNC, BT_SEG1, BT_SEG2} bt_state_e;

    localparam int BRP_W_DEF   = 6;
    localparam int TSEG1_W_DEF = 4;
    localparam int TSEG2_W_DEF = 3;
    localparam int SJW_W_DEF   = 2;

endpackage

// File: rtl/can_tq_prescaler.sv
// rtl/can_tq_prescaler.sv - time quantum prescaler; tq_tick marks the last clk of every tq
module can_tq_prescaler
    import can_pkg::*;
#(
    parameter int BRP_W = BRP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             restart,
    input  logic [BRP_W-1:0] brp,
    output logic             tq_tick
);

    logic [BRP_W-1:0] tq_cnt;

    assign tq_tick = (tq_cnt == brp);

    // restart realigns the tq grid to the clk after a sync edge
    always_ff @(posedge clk) begin
        if (!rst_n || clear || restart || tq_tick) begin
            tq_cnt <= '0;
        end else begin
            tq_cnt <= tq_cnt + BRP_W'(1);
        end
    end

endmodule

// File: rtl/can_bit_timing.sv
// rtl/can_bit_timing.sv - CAN receive bit timing with hard sync and SJW-limited resync; CAN_TRIPLE_SAMPLE_EN selects majority sampling
module can_bit_timing
    import can_pkg::*;
#(
    parameter int BRP_W   = BRP_W_DEF,
    parameter int TSEG1_W = TSEG1_W_DEF,
    parameter int TSEG2_W = TSEG2_W_DEF,
    parameter int SJW_W   = SJW_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reset_mode,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               hard_sync_en,
    input  logic               rx_i,
    output logic               bit_start_point,
    output logic               rx_bit_curr,
    output logic               rx_bit_prev,
    output logic               tx_point
);

    localparam int SW = TSEG1_W + 1;

    logic [BRP_W-1:0]   brp_q;
    logic [TSEG1_W-1:0] tseg1_q;
    logic [TSEG2_W-1:0] tseg2_q;
    logic [SJW_W-1:0]   sjw_q;

    bt_state_e state;
    logic [SW-1:0] seg_cnt, ext, shr;
    logic [SW-1:0] sjw_p1, e_pos, r_neg, ext_eff, shr_eff, seg1_last, seg2_last;
    logic synced, rx_q, tq_tick, restart, in_reset;
    logic edge_det, hard_sync, resync_edge, early_end, sample;

    always_comb begin
        in_reset    = !rst_n || reset_mode;
        edge_det    = rx_q & ~rx_i;
        hard_sync   = edge_det & hard_sync_en;
        resync_edge = edge_det & rx_bit_curr & ~synced;
        sjw_p1      = SW'(sjw_q) + SW'(1);
        e_pos       = seg_cnt + SW'(1);
        r_neg       = SW'(tseg2_q) + SW'(1) - seg_cnt;
        ext_eff     = ext;
        shr_eff     = shr;
        early_end   = 1'b0;
        if (resync_edge && !hard_sync) begin
            case (state)
                BT_SEG1: ext_eff = (e_pos < sjw_p1) ? e_pos : sjw_p1;
                BT_SEG2: begin
                    if (r_neg <= sjw_p1) early_end = 1'b1;
                    else                 shr_eff   = sjw_p1;
                end
                default: ;
            endcase
        end
        // the effective ext/shr let an edge and a tq_tick in the same clk combine correctly
        seg1_last = SW'(tseg1_q) + ext_eff;
        seg2_last = SW'(tseg2_q) - shr_eff;
        restart   = !in_reset && (hard_sync || early_end);
    end

    can_tq_prescaler #(.BRP_W(BRP_W)) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (reset_mode),
        .restart (restart),
        .brp     (brp_q),
        .tq_tick (tq_tick)
    );

`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0] tri_q;

    always_ff @(posedge clk) begin
        if (in_reset) begin
            tri_q <= 2'b11;
        end else if (tq_tick && state == BT_SEG1) begin
            tri_q <= {tri_q[0], rx_i};
        end
    end

    assign sample = (tseg1_q >= TSEG1_W'(2))
                  ? ((tri_q[1] & tri_q[0]) | (tri_q[1] & rx_i) | (tri_q[0] & rx_i))
                  : rx_i;
`else
    assign sample = rx_i;
`endif

    always_ff @(posedge clk) begin
        if (in_reset) begin
            brp_q           <= brp;
            tseg1_q         <= tseg1;
            tseg2_q         <= tseg2;
            sjw_q           <= sjw;
            state           <= BT_SYNC;
            seg_cnt         <= '0;
            ext             <= '0;
            shr             <= '0;
            synced          <= 1'b0;
            rx_q            <= 1'b1;
            bit_start_point <= 1'b0;
            tx_point        <= 1'b0;
            rx_bit_curr     <= 1'b1;
            rx_bit_prev     <= 1'b1;
        end else begin
            rx_q            <= rx_i;
            bit_start_point <= 1'b0;
            tx_point        <= 1'b0;
            if (hard_sync) begin
                state   <= BT_SEG1;
                seg_cnt <= '0;
                ext     <= '0;
                shr     <= '0;
                synced  <= 1'b1;
            end else if (early_end) begin
                state   <= BT_SEG1;
                seg_cnt <= '0;
                shr     <= '0;
                synced  <= 1'b1;
            end else begin
                if (resync_edge && state == BT_SEG1) begin
                    ext    <= ext_eff;
                    synced <= 1'b1;
                end
                if (resync_edge && state == BT_SEG2) begin
                    shr    <= shr_eff;
                    synced <= 1'b1;
                end
                if (tq_tick) begin
                    case (state)
                        BT_SYNC: begin
                            state   <= BT_SEG1;
                            seg_cnt <= '0;
                        end
                        BT_SEG1: begin
                            if (seg_cnt >= seg1_last) begin
                                state           <= BT_SEG2;
                                seg_cnt         <= '0;
                                ext             <= '0;
                                synced          <= 1'b0;
                                bit_start_point <= 1'b1;
                                rx_bit_prev     <= rx_bit_curr;
                                rx_bit_curr     <= sample;
                            end else begin
                                seg_cnt <= seg_cnt + SW'(1);
                            end
                        end
                        BT_SEG2: begin
                            if (seg_cnt >= seg2_last) begin
                                state    <= BT_SYNC;
                                seg_cnt  <= '0;
                                shr      <= '0;
                                tx_point <= 1'b1;
                            end else begin
                                seg_cnt <= seg_cnt + SW'(1);
                            end
                        end
                        default: state <= BT_SYNC;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_timing.sv
// tb/tb_can_bit_timing.sv - randomized self-checking bench for can_bit_timing against an arithmetic bit-timing model
module tb_can_bit_timing;

    logic       clk = 1'b0;
    logic       rst_n, reset_mode, hard_sync_en, rx_i;
    logic [5:0] brp;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic [1:0] sjw;
    logic       bit_start_point, rx_bit_curr, rx_bit_prev, tx_point;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int bsp_t[$], bsp_c[$], bsp_p[$], tx_t[$];
    int r0, qq, nn, t1, t2, sj;

    can_bit_timing dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .reset_mode      (reset_mode),
        .brp             (brp),
        .tseg1           (tseg1),
        .tseg2           (tseg2),
        .sjw             (sjw),
        .hard_sync_en    (hard_sync_en),
        .rx_i            (rx_i),
        .bit_start_point (bit_start_point),
        .rx_bit_curr     (rx_bit_curr),
        .rx_bit_prev     (rx_bit_prev),
        .tx_point        (tx_point)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bit_start_point) begin
            bsp_t.push_back(cyc);
            bsp_c.push_back(int'(rx_bit_curr));
            bsp_p.push_back(int'(rx_bit_prev));
        end
        if (tx_point) tx_t.push_back(cyc);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Holds reset_mode for a few clks with the new configuration; r0 is the first free-running clk
    task automatic do_reset(input int b, input int s1, input int s2, input int j);
        reset_mode = 1'b1;
        brp = 6'(b); tseg1 = 4'(s1); tseg2 = 3'(s2); sjw = 2'(j);
        qq = b + 1; t1 = s1; t2 = s2; sj = j;
        nn = qq * (t1 + t2 + 3);
        step(3);
        bsp_t.delete(); bsp_c.delete(); bsp_p.delete(); tx_t.delete();
        reset_mode = 1'b0;
        r0 = cyc;
    endtask

    task automatic free_run(input int b, input int s1, input int s2, input int j);
        rx_i = 1'b1; hard_sync_en = 1'b0;
        do_reset(b, s1, s2, j);
        check_eq("rst_bsp", int'(bit_start_point), 0);
        check_eq("rst_tx", int'(tx_point), 0);
        check_eq("rst_curr", int'(rx_bit_curr), 1);
        check_eq("rst_prev", int'(rx_bit_prev), 1);
        step(3 * nn + 5);
        for (int k = 0; k < 3; k++) begin
            check_eq("free_bsp_t", qget(bsp_t, k), r0 + (t1 + 2) * qq + k * nn);
            check_eq("free_curr", qget(bsp_c, k), 1);
            check_eq("free_prev", qget(bsp_p, k), 1);
        end
        for (int k = 0; k < 2; k++) check_eq("free_tx_t", qget(tx_t, k), r0 + (k + 1) * nn);
    endtask

    task automatic hard_sync_run(input int b, input int s1, input int s2, input int j);
        int t_edge, s_k, b_k;
        int data[5];
        rx_i = 1'b1; hard_sync_en = 1'b1;
        do_reset(b, s1, s2, j);
        step(1 + int'($urandom_range(0, (t1 + 1) * qq - 1)));
        t_edge = cyc;
        rx_i = 1'b0;
        data[0] = 0;
        step(1);
        hard_sync_en = 1'b0;
        for (int k = 1; k < 5; k++) begin
            data[k] = int'($urandom_range(0, 1));
            s_k = t_edge + 1 + (t1 + t2 + 2) * qq + (k - 1) * nn;
            step(s_k - cyc);
            rx_i = data[k][0];
        end
        b_k = t_edge + (t1 + 1) * qq + 1;
        step(b_k + 4 * nn + 2 - cyc);
        for (int k = 0; k < 5; k++) begin
            check_eq("hs_bsp_t", qget(bsp_t, k), b_k + k * nn);
            check_eq("hs_curr", qget(bsp_c, k), data[k]);
            check_eq("hs_prev", qget(bsp_p, k), (k == 0) ? 1 : data[k - 1]);
        end
        for (int k = 1; k < 4; k++)
            check_eq("hs_tx_t", qget(tx_t, k - 1), t_edge + 1 + (t1 + t2 + 2) * qq + (k - 1) * nn);
    endtask

    // Bit 0 is recessive; one falling edge lands d clks into bit 1 and the line stays dominant
    task automatic resync_run(input int b, input int s1, input int s2, input int j, input int d);
        int s, k, e, jj, r, b1, b2, c1, p2;
        rx_i = 1'b1; hard_sync_en = 1'b0;
        do_reset(b, s1, s2, j);
        s = r0 + nn;
        step(s + d - cyc);
        rx_i = 1'b0;
        k = d / qq;
        if (k == 0) begin
            b1 = s + (t1 + 2) * qq; c1 = 0; b2 = b1 + nn; p2 = 0;
        end else if (k <= t1 + 1) begin
            e = (k < sj + 1) ? k : sj + 1;
            b1 = s + (t1 + 2 + e) * qq; c1 = 0; b2 = b1 + nn; p2 = 0;
        end else begin
            b1 = s + (t1 + 2) * qq; c1 = 1; p2 = 1;
            jj = k - t1 - 2;
            r = t2 + 1 - jj;
            if (r <= sj + 1) b2 = s + d + 1 + (t1 + 1) * qq;
            else             b2 = s + (t1 + t2 + 3 - (sj + 1)) * qq + (t1 + 2) * qq;
        end
        step(r0 + 5 * nn - cyc);
        check_eq("rs_bsp0_t", qget(bsp_t, 0), r0 + (t1 + 2) * qq);
        check_eq("rs_bsp1_t", qget(bsp_t, 1), b1);
        check_eq("rs_bsp1_curr", qget(bsp_c, 1), c1);
        check_eq("rs_bsp1_prev", qget(bsp_p, 1), 1);
        check_eq("rs_bsp2_t", qget(bsp_t, 2), b2);
        check_eq("rs_bsp2_curr", qget(bsp_c, 2), 0);
        check_eq("rs_bsp2_prev", qget(bsp_p, 2), p2);
    endtask

    task automatic reset_mid_run();
        int n_seen;
        rx_i = 1'b0; hard_sync_en = 1'b0;
        do_reset(1, 5, 2, 0);
        step(2 * nn + qq + 3);
        check_eq("mid_pre_curr", qget(bsp_c, 1), 0);
        check_eq("mid_pre_prev", qget(bsp_p, 1), 0);
        reset_mode = 1'b1;
        step(1);
        check_eq("mid_bsp", int'(bit_start_point), 0);
        check_eq("mid_tx", int'(tx_point), 0);
        check_eq("mid_curr", int'(rx_bit_curr), 1);
        check_eq("mid_prev", int'(rx_bit_prev), 1);
        n_seen = bsp_t.size();
        step(2 * nn);
        check_eq("mid_no_bsp", bsp_t.size(), n_seen);
        do_reset(1, 5, 2, 0);
        step(nn);
        check_eq("mid_after_t", qget(bsp_t, 0), r0 + 14);
        check_eq("mid_after_curr", qget(bsp_c, 0), 0);
        check_eq("mid_after_prev", qget(bsp_p, 0), 1);
    endtask

    // Bit 0 dominant disables resync; bit 1 recessive with a one-clk dip on one of its last three SEG1 ticks
    task automatic glitch_run(input int b, input int s1, input int s2, input int m);
        int s, g, exp_bit;
        rx_i = 1'b0; hard_sync_en = 1'b0;
        do_reset(b, s1, s2, 0);
        s = r0 + nn;
        step(s - cyc);
        rx_i = 1'b1;
        g = s + (t1 + 2) * qq - 1 - m * qq;
        step(g - cyc);
        rx_i = 1'b0;
        step(1);
        rx_i = 1'b1;
        step(s + (t1 + 2) * qq + 2 - cyc);
`ifdef CAN_TRIPLE_SAMPLE_EN
        exp_bit = 1;
`else
        exp_bit = (m == 0) ? 0 : 1;
`endif
        check_eq("gl_bsp0_curr", qget(bsp_c, 0), 0);
        check_eq("gl_bsp1_t", qget(bsp_t, 1), s + (t1 + 2) * qq);
        check_eq("gl_bsp1_curr", qget(bsp_c, 1), exp_bit);
    endtask

    initial begin
        rst_n = 1'b0; reset_mode = 1'b1; hard_sync_en = 1'b0; rx_i = 1'b1;
        brp = 6'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd0;
        step(3);
        rst_n = 1'b1;

        free_run(1, 5, 2, 0);
        hard_sync_run(1, 5, 2, 0);
        resync_run(1, 5, 2, 0, 4);
        resync_run(1, 5, 2, 0, 14);
        reset_mid_run();
        for (int m = 0; m < 3; m++) glitch_run(1, 5, 2, m);

        for (int i = 0; i < 6; i++) begin
            free_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            hard_sync_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            glitch_run(int'($urandom_range(0, 3)), int'($urandom_range(2, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 30; i++) begin
            int b, s1, s2, j, nb;
            b = int'($urandom_range(0, 3));
            s1 = int'($urandom_range(0, 7));
            s2 = int'($urandom_range(0, 7));
            j = int'($urandom_range(0, 3));
            nb = (b + 1) * (s1 + s2 + 3);
            resync_run(b, s1, s2, j, int'($urandom_range(0, nb - 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
